// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255 PPI bus master:
// op codes, register addresses and FSM states.
package ppi_pkg;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_BSR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] PA   = 2'b00;
  localparam logic [1:0] PB   = 2'b01;
  localparam logic [1:0] PC   = 2'b10;
  localparam logic [1:0] CTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  // Port-C bit set/reset control word
  function automatic logic [7:0] bsr_word(input logic [7:0] w);
    return {4'b0000, w[2:0], w[3]};
  endfunction

endpackage

// File: rtl/ppi_bus_master.sv
// Bus master driving an 8255 PPI: timed CS_n/RD_n/WR_n cycles,
// port-C bit set/reset and an optional power-up control word.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1,
  parameter bit         INIT_EN    = 1'b1,
  parameter logic [7:0] INIT_CW    = 8'h9B
) (
  input  logic       clk,
  input  logic       RESET_n,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic [1:0] A,
  output logic [7:0] DOut,
  input  logic [7:0] DIn
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       boot_q, boot_d;
  logic       acc_rd_q, acc_rd_d;
  logic [1:0] acc_a_q, acc_a_d;
  logic [7:0] acc_d_q, acc_d_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic [1:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;

  logic       active;
  logic       strobe;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    boot_d   = boot_q;
    acc_rd_d = acc_rd_q;
    acc_a_d  = acc_a_q;
    acc_d_d  = acc_d_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // first cycle after reset: optional init write
        if (pend_q) begin
          pend_d = 1'b0;
          if (INIT_EN) begin
            state_d  = INIT;
            cnt_d    = SETUP_LD;
            boot_d   = 1'b1;
            acc_rd_d = 1'b0;
            acc_a_d  = CTRL;
            acc_d_d  = INIT_CW;
          end
        end else if (req) begin
          if (op == OP_ILL ||
              (op == OP_RD && addr == CTRL)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d  = SETUP;
            cnt_d    = SETUP_LD;
            boot_d   = 1'b0;
            acc_rd_d = (op == OP_RD);
            acc_a_d  = (op == OP_BSR) ? CTRL : addr;
            unique case (1'b1)
              op == OP_WR:  acc_d_d = wdata;
              op == OP_BSR: acc_d_d = bsr_word(wdata);
              default:      acc_d_d = 8'h00;
            endcase
          end
        end
      end
      INIT, SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          if (acc_rd_q) rdata_d = DIn;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = boot_q ? IDLE : DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    active = (state_d == INIT) || (state_d == SETUP) ||
             (state_d == STROBE) || (state_d == HOLD);
    strobe = (state_d == STROBE);

    busy_d = active;
    done_d = (state_d == DONE);
    cs_n_d = !active;
    rd_n_d = !(strobe && acc_rd_d);
    wr_n_d = !(strobe && !acc_rd_d);
    a_d    = active ? acc_a_d : 2'b00;
    dout_d = (active && !acc_rd_d) ? acc_d_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pend_q   <= 1'b1;
      boot_q   <= 1'b0;
      acc_rd_q <= 1'b0;
      acc_a_q  <= 2'b00;
      acc_d_q  <= 8'h00;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_q      <= 2'b00;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      boot_q   <= boot_d;
      acc_rd_q <= acc_rd_d;
      acc_a_q  <= acc_a_d;
      acc_d_q  <= acc_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign CS_n  = cs_n_q;
  assign RD_n  = rd_n_q;
  assign WR_n  = wr_n_q;
  assign A     = a_q;
  assign DOut  = dout_q;

endmodule
